// File: rtl/delay_calib_if.sv
// Bus bundle between the calibration controller and its user / delay line.
// master drives requests and line data; slave is the controller.
interface delay_calib_if;
  logic        start;
  logic        cfg_wr;
  logic [15:0] cfg_data;
  logic [63:0] din;
  logic [15:0] cfg_out;
  logic        busy;
  logic        done;
  logic [3:0]  fail;

  modport master (
    output start, cfg_wr, cfg_data, din,
    input  cfg_out, busy, done, fail
  );

  modport slave (
    input  start, cfg_wr, cfg_data, din,
    output cfg_out, busy, done, fail
  );
endinterface

// File: rtl/delay_calib.sv
// Tap sweep calibration for the four-lane SRL delay line: finds each lane's
// longest error-free tap window and programs the lane to its centre.
module delay_calib #(
  parameter logic [15:0] TRAIN  = 16'hA5C3,
  parameter int          SETTLE = 20,
  parameter int          DWELL  = 256
) (
  input logic          aclk,
  input logic          areset,
  delay_calib_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE, S_FINISH} state_t;

  state_t      state_reg;
  logic [3:0]  tap_reg;
  logic [15:0] cnt_reg;
  logic [63:0] din_reg;
  logic [15:0] cfg_out_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [3:0]  fail_reg;

  logic        sweep_init;
  logic        dwell_end;
  logic [3:0]  fail_next;
  logic [15:0] cfg_fin;

  assign sweep_init = (state_reg == S_IDLE) && bus.start;
  assign dwell_end  = (state_reg == S_MEASURE) && (cnt_reg == 16'(DWELL - 1));

  always_ff @(posedge aclk) begin
    if (areset) din_reg <= '0;
    else        din_reg <= bus.din;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       err_reg;
    logic [3:0] cur_start_reg;
    logic [4:0] cur_len_reg;
    logic [3:0] best_start_reg;
    logic [4:0] best_len_reg;
    logic       err_now;
    logic [3:0] fin_start;
    logic [4:0] fin_len;

    // err_now folds in the current cycle so the last dwell cycle still counts
    assign err_now   = err_reg | (din_reg[16*gi +: 16] != TRAIN);
    assign fin_start = (cur_len_reg > best_len_reg) ? cur_start_reg : best_start_reg;
    assign fin_len   = (cur_len_reg > best_len_reg) ? cur_len_reg   : best_len_reg;
    assign fail_next[gi]       = (fin_len == 5'd0);
    assign cfg_fin[4*gi +: 4]  = fail_next[gi] ? 4'h0
                                 : fin_start + 4'((fin_len - 5'd1) >> 1);

    always_ff @(posedge aclk) begin
      if (areset || sweep_init) begin
        err_reg        <= 1'b0;
        cur_start_reg  <= 4'h0;
        cur_len_reg    <= 5'd0;
        best_start_reg <= 4'h0;
        best_len_reg   <= 5'd0;
      end else begin
        if (state_reg == S_SETTLE)       err_reg <= 1'b0;
        else if (state_reg == S_MEASURE) err_reg <= err_now;

        if (dwell_end) begin
          if (!err_now) begin
            if (cur_len_reg == 5'd0) cur_start_reg <= tap_reg;
            cur_len_reg <= cur_len_reg + 5'd1;
          end else begin
            // strict compare: on a tie the earlier run is kept
            if (cur_len_reg > best_len_reg) begin
              best_start_reg <= cur_start_reg;
              best_len_reg   <= cur_len_reg;
            end
            cur_len_reg <= 5'd0;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg   <= S_IDLE;
      tap_reg     <= 4'h0;
      cnt_reg     <= 16'h0;
      cfg_out_reg <= 16'h0000;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      fail_reg    <= 4'h0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            tap_reg     <= 4'h0;
            cnt_reg     <= 16'h0;
            cfg_out_reg <= 16'h0000;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
            fail_reg    <= 4'h0;
            state_reg   <= S_SETTLE;
          end else if (bus.cfg_wr) begin
            cfg_out_reg <= bus.cfg_data;
          end
        end
        S_SETTLE: begin
          if (cnt_reg == 16'(SETTLE - 1)) begin
            cnt_reg   <= 16'h0;
            state_reg <= S_MEASURE;
          end else begin
            cnt_reg <= cnt_reg + 16'h1;
          end
        end
        S_MEASURE: begin
          if (dwell_end) begin
            cnt_reg <= 16'h0;
            if (tap_reg != 4'hF) begin
              tap_reg     <= tap_reg + 4'h1;
              cfg_out_reg <= {4{tap_reg + 4'h1}};
              state_reg   <= S_SETTLE;
            end else begin
              state_reg <= S_FINISH;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'h1;
          end
        end
        S_FINISH: begin
          cfg_out_reg <= cfg_fin;
          fail_reg    <= fail_next;
          done_reg    <= 1'b1;
          busy_reg    <= 1'b0;
          state_reg   <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.cfg_out = cfg_out_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.fail    = fail_reg;

endmodule

// File: doc/delay_calib.md
# delay_calib

Calibration controller for the 64-bit, four-lane SRL delay line. It drives the line's 16-bit tap configuration (four 4-bit fields, one per 16-bit lane) and watches the delayed data. On request it sweeps all 16 taps while a constant training word is present, then programs each lane to the centre of its longest error-free tap window. When idle, software can also load the configuration word directly.

## Interface

Parameters:
- TRAIN, 16'hA5C3: expected 16-bit word on every lane during calibration.
- SETTLE, 20: cycles waited after each tap change before comparing; legal range 17 to 255.
- DWELL, 256: compare cycles per tap; legal range 1 to 65535.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin calibration.
- cfg_wr  in  1  one-cycle request to load cfg_data into cfg_out.
- cfg_data  in  16  manual tap word, lane k in bits [4k+3:4k].
- din  in  64  delayed data from the delay line; lane k is bits [16k+15:16k].
- cfg_out  out  16  tap word to the delay line's cfg input.
- busy  out  1  high while a sweep is in progress.
- done  out  1  sticky; set when a sweep completes, cleared by the next accepted start.
- fail  out  4  per lane; set when the lane had no error-free tap in the last sweep.

## Operation

- States: IDLE, SETTLE, MEASURE, FINISH.
- IDLE
  - start=1: tap=0, cfg_out=16'h0000, all run trackers cleared, done=0, fail=0, busy=1, go to SETTLE.
  - else cfg_wr=1: cfg_out<=cfg_data.
  - start and cfg_wr in the same cycle: start wins, cfg_wr is dropped.
- SETTLE: count SETTLE cycles, then go to MEASURE. Per-lane error flags are cleared on entry.
- MEASURE
  - Each cycle, for every lane k: if the registered lane word differs from TRAIN, set err[k].
  - After DWELL cycles, update each lane's run tracker (below).
  - If tap<15: tap+1, cfg_out = tap replicated into all four fields, go to SETTLE.
  - If tap=15: go to FINISH.
- Run tracker, per lane: cur_start (4b), cur_len (5b), best_start (4b), best_len (5b).
  - err=0: if cur_len=0 then cur_start=tap; cur_len+1.
  - err=1: close the run (below), then cur_len=0.
  - Closing a run: if cur_len > best_len (strictly greater), copy cur_start/cur_len into best_start/best_len. Ties keep the earlier run.
- FINISH (one cycle)
  - Close all open runs, including the tap-15 update.
  - Per lane: if best_len=0, field=0 and fail[k]=1; else field = best_start + ((best_len-1)>>1), truncated to 4 bits.
  - cfg_out updated, done=1, busy=0, return to IDLE.
- Taps 15 and 0 are not adjacent: no wrap-around run merging.
- start and cfg_wr are ignored while busy.

## Timing

- Reset values: cfg_out=16'h0000, busy=0, done=0, fail=4'h0, state IDLE, tap=0. Reset during a sweep aborts it; the next cycle shows these reset values.
- din is registered once before the compare. SETTLE≥17 therefore covers 15 SRL cycles plus the input register plus margin.
- Start accepted at edge t:
  - busy=1 and cfg_out=0 from t+1.
  - Each tap occupies SETTLE+DWELL cycles.
  - done=1, busy=0 and the final cfg_out all appear at t+2+16*(SETTLE+DWELL) (defaults: t+4418).
- cfg_wr accepted at edge t: cfg_out=cfg_data from t+1, no other effect.
- cfg_out changes only on tap steps, at FINISH, on an accepted cfg_wr, or on reset.

## Test plan

- Reset mid-sweep: assert areset at tap 7 -> next cycle cfg_out=0, busy=0, done=0, fail=0; a later start runs a full sweep normally.
- Clean window: bench delay model where lane 0 matches TRAIN only at taps 4..9, lane 1 at 0..15, lane 2 at 12..15, lane 3 at 3..3 -> cfg_out=16'h3D76, done at t+4418, fail=0.
- Tie and split windows: lane 0 good at 1..3 and 8..10 -> field 2 (earlier run wins); lane 0 good at 0..1 and 5..9 -> field 7.
- No good tap: lane 2 never matches -> fail=4'b0100, lane 2 field=0, other lanes calibrated.
- Manual and arbitration: cfg_wr with 16'hBEEF in IDLE -> cfg_out=16'hBEEF next cycle. cfg_wr during busy -> ignored. start+cfg_wr in the same cycle -> sweep starts, cfg_out=0.
- Re-start: start pulses during busy -> ignored. start after done -> done clears next cycle, new sweep result replaces the old one.
